// File: rtl/tx_sched_pkg.sv
// Shared types and pattern generators for the TX lane scheduler and the PRBS7 generator.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    DATA  = 2'd2
  } state_t;

  // Widest word the pattern helpers can build (STAGES up to 5).
  localparam int PRBS_MAX_W = 32;

  typedef struct packed {
    logic [6:0]            lfsr;
    logic [PRBS_MAX_W-1:0] word;
  } prbs_step_t;

  // Alternating 1,0,1,0 line pattern, bit 0 leaves the serializer first.
  function automatic logic [PRBS_MAX_W-1:0] clk_pattern(input int width);
    logic [PRBS_MAX_W-1:0] w;
    w = '0;
    for (int i = 0; i < PRBS_MAX_W; i++) begin
      if (i < width) w[i] = ((i % 2) == 0);
    end
    return w;
  endfunction

  // x^7+x^6+1 Fibonacci LFSR advanced nbits times; each feedback bit is also the output bit.
  function automatic prbs_step_t prbs7_step(input logic [6:0] lfsr, input int nbits);
    prbs_step_t r;
    logic [6:0] s;
    logic       fb;
    s      = lfsr;
    r.word = '0;
    for (int i = 0; i < PRBS_MAX_W; i++) begin
      if (i < nbits) begin
        fb        = s[6] ^ s[5];
        r.word[i] = fb;
        s         = {s[5:0], fb};
      end
    end
    r.lfsr = s;
    return r;
  endfunction

endpackage

// File: rtl/prbs7_gen.sv
// Word-parallel PRBS7 source: seed load, per-word advance, combinational word output.
module prbs7_gen
  import tx_sched_pkg::*;
#(
  parameter int         WIDTH = 32,
  parameter logic [6:0] SEED  = 7'h7F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] word
);

  logic [6:0] lfsr;
  prbs_step_t step;

  always_comb begin
    step = prbs7_step(lfsr, WIDTH);
  end

  assign word = step.word[WIDTH-1:0];

  // Load has priority so a fresh burst always starts from the seed.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      lfsr <= SEED;
    end else if (advance) begin
      lfsr <= step.lfsr;
    end
  end

endmodule

// File: rtl/tx_lane_sched.sv
// Word-rate scheduler choosing idle, training pattern or mainband data for the tree serializer input.
module tx_lane_sched
  import tx_sched_pkg::*;
#(
  parameter int              STAGES      = 5,
  localparam int             WIDTH       = 2 ** STAGES,
  parameter int              TRAIN_WORDS = 16,
  parameter logic [WIDTH-1:0] IDLE_WORD  = '0,
  parameter logic [6:0]      PRBS_SEED   = 7'h7F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             train_req,
  input  logic             train_mode,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             data_ready,
  output logic [WIDTH-1:0] ser_din,
  output logic             training,
  output logic             train_done,
  output logic             train_pend
);

  localparam int               CW       = $clog2(TRAIN_WORDS + 1);
  localparam logic [CW-1:0]    LAST     = CW'(TRAIN_WORDS - 1);
  localparam logic [WIDTH-1:0] CLK_WORD = WIDTH'(clk_pattern(WIDTH));

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             mode;
  logic [WIDTH-1:0] prbs_word;

  // The LFSR sits at the seed whenever no burst is running.
  prbs7_gen #(
    .WIDTH (WIDTH),
    .SEED  (PRBS_SEED)
  ) u_prbs (
    .clk     (clk),
    .rst     (rst),
    .load    (state != TRAIN),
    .advance (state == TRAIN),
    .word    (prbs_word)
  );

  assign data_ready = (state == DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ser_din    <= IDLE_WORD;
      training   <= 1'b0;
      train_done <= 1'b0;
      train_pend <= 1'b0;
      cnt        <= '0;
      mode       <= 1'b0;
    end else begin
      train_done <= 1'b0;
      unique case (state)
        IDLE: begin
          ser_din <= IDLE_WORD;
          if (train_req || train_pend) begin
            state      <= TRAIN;
            training   <= 1'b1;
            train_pend <= 1'b0;
            mode       <= train_mode;
            cnt        <= '0;
          end else if (data_valid) begin
            state <= DATA;
          end
        end
        TRAIN: begin
          ser_din <= mode ? prbs_word : CLK_WORD;
          if (train_req) train_pend <= 1'b1;
          if (cnt == LAST) begin
            state      <= IDLE;
            training   <= 1'b0;
            train_done <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          // A word offered alongside a training request is still taken.
          ser_din <= data_valid ? data_in : IDLE_WORD;
          if (train_req || train_pend) begin
            state      <= TRAIN;
            training   <= 1'b1;
            train_pend <= 1'b0;
            mode       <= train_mode;
            cnt        <= '0;
          end else if (!data_valid) begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          ser_din  <= IDLE_WORD;
          training <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_lane_sched.sv
// Directed self-checking bench for tx_lane_sched: reset, streaming, training bursts, preemption, pending and abort.
module tb_tx_lane_sched;

  localparam int          W        = 32;
  localparam logic [W-1:0] CLK_WORD = 32'h5555_5555;
  localparam logic [W-1:0] PRBS_W0  = 32'h4F14_3040;

  logic         clk = 1'b0;
  logic         rst;
  logic         train_req;
  logic         train_mode;
  logic         data_valid;
  logic [W-1:0] data_in;
  logic         data_ready;
  logic [W-1:0] ser_din;
  logic         training;
  logic         train_done;
  logic         train_pend;

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] prbs_model [16];
  logic [W-1:0] first_word;

  always #5 clk = ~clk;

  tx_lane_sched #(
    .STAGES      (5),
    .TRAIN_WORDS (16),
    .IDLE_WORD   (32'h0000_0000),
    .PRBS_SEED   (7'h7F)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .train_req  (train_req),
    .train_mode (train_mode),
    .data_valid (data_valid),
    .data_in    (data_in),
    .data_ready (data_ready),
    .ser_din    (ser_din),
    .training   (training),
    .train_done (train_done),
    .train_pend (train_pend)
  );

  // PRBS7 reference from the recurrence b[n] = b[n-7] ^ b[n-6], history seeded with 7'h7F.
  task automatic buildPrbsModel();
    logic b [0:7+16*W-1];
    logic [6:0] seed;
    seed = 7'h7F;
    for (int j = 0; j < 7; j++) b[j] = seed[6-j];
    for (int n = 7; n < 7 + 16 * W; n++) b[n] = b[n-7] ^ b[n-6];
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < W; i++) prbs_model[k][i] = b[7 + k * W + i];
    end
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic mode, input logic valid,
                               input logic [W-1:0] din);
    train_req  = req;
    train_mode = mode;
    data_valid = valid;
    data_in    = din;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a one-cycle request from IDLE and checks the TRAIN entry cycle.
  task automatic startTrain(input logic mode);
    train_mode = mode;
    train_req  = 1'b1;
    step();
    train_req = 1'b0;
    checkOutput("entry_training", 32'(training), 32'd1);
    checkOutput("entry_pend", 32'(train_pend), 32'd0);
    checkOutput("entry_ready", 32'(data_ready), 32'd0);
  endtask

  // Walks the 16 burst words; optional request pulses at words req_a/req_b, mode flipped mid-burst.
  task automatic trainBurst(input logic mode, input int req_a, input int req_b);
    logic pend_exp;
    pend_exp = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      train_req  = (k == req_a) || (k == req_b);
      train_mode = (k > 1) ? ~mode : mode;
      step();
      if (train_req) pend_exp = 1'b1;
      train_req = 1'b0;
      if (k == 1) first_word = ser_din;
      checkOutput($sformatf("word%0d_m%0d", k - 1, mode), ser_din,
                  mode ? prbs_model[k-1] : CLK_WORD);
      checkOutput($sformatf("training_w%0d", k - 1), 32'(training), 32'(k < 16));
      checkOutput($sformatf("done_w%0d", k - 1), 32'(train_done), 32'(k == 16));
      checkOutput($sformatf("pend_w%0d", k - 1), 32'(train_pend), 32'(pend_exp));
      checkOutput($sformatf("ready_w%0d", k - 1), 32'(data_ready), 32'd0);
    end
    train_mode = mode;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    buildPrbsModel();

    // Reset held three clocks with upstream offering data.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("rst_ser_din", ser_din, 32'h0);
      checkOutput("rst_ready", 32'(data_ready), 32'd0);
      checkOutput("rst_training", 32'(training), 32'd0);
      checkOutput("rst_done", 32'(train_done), 32'd0);
      checkOutput("rst_pend", 32'(train_pend), 32'd0);
    end
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("post_rst_ready", 32'(data_ready), 32'd0);
    step();
    checkOutput("idle_ready", 32'(data_ready), 32'd0);

    // Streaming words 1,2,3.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd1);
    step();
    checkOutput("data_entry_ready", 32'(data_ready), 32'd1);
    checkOutput("data_entry_ser", ser_din, 32'h0);
    step();
    checkOutput("stream_w1", ser_din, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd2);
    step();
    checkOutput("stream_w2", ser_din, 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd3);
    step();
    checkOutput("stream_w3", ser_din, 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("ready_valid_low", 32'(data_ready), 32'd1);
    step();
    checkOutput("stream_idle", ser_din, 32'h0);
    checkOutput("stream_ready_drop", 32'(data_ready), 32'd0);

    // Clock-pattern burst.
    startTrain(1'b0);
    checkOutput("clk_entry_ser", ser_din, 32'h0);
    trainBurst(1'b0, 0, 0);
    step();
    checkOutput("clk_after_ser", ser_din, 32'h0);
    checkOutput("clk_after_done", 32'(train_done), 32'd0);
    checkOutput("clk_after_training", 32'(training), 32'd0);

    // Two back-to-back PRBS bursts, each restarting from the seed.
    startTrain(1'b1);
    trainBurst(1'b1, 0, 0);
    startTrain(1'b1);
    trainBurst(1'b1, 0, 0);
    checkOutput("prbs_restart_w0", first_word, PRBS_W0);
    step();

    // Preemption: A accepted alongside the request, B waits for DATA again.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hA5A5_0001);
    step();
    checkOutput("pre_ready", 32'(data_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hA5A5_0001);
    step();
    checkOutput("pre_word_a", ser_din, 32'hA5A5_0001);
    checkOutput("pre_training", 32'(training), 32'd1);
    checkOutput("pre_ready_train", 32'(data_ready), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hB0B0_0002);
    trainBurst(1'b0, 0, 0);
    step();
    checkOutput("pre_back_data", 32'(data_ready), 32'd1);
    checkOutput("pre_back_ser", ser_din, 32'h0);
    step();
    checkOutput("pre_word_b", ser_din, 32'hB0B0_0002);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    checkOutput("pre_end_ser", ser_din, 32'h0);

    // Two requests during a burst collapse into exactly one more burst.
    startTrain(1'b0);
    trainBurst(1'b0, 4, 9);
    step();
    checkOutput("pend_entry_training", 32'(training), 32'd1);
    checkOutput("pend_entry_clear", 32'(train_pend), 32'd0);
    trainBurst(1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("pend_no_third", 32'(training), 32'd0);
      checkOutput("pend_stays_low", 32'(train_pend), 32'd0);
    end

    // Reset at word 8 aborts the burst and drops the pending request.
    startTrain(1'b0);
    for (int k = 1; k <= 8; k++) begin
      train_req = (k == 3);
      step();
      train_req = 1'b0;
      checkOutput("abort_word", ser_din, CLK_WORD);
    end
    checkOutput("abort_pend_set", 32'(train_pend), 32'd1);
    rst = 1'b1;
    step();
    checkOutput("abort_ser", ser_din, 32'h0);
    checkOutput("abort_pend", 32'(train_pend), 32'd0);
    checkOutput("abort_training", 32'(training), 32'd0);
    checkOutput("abort_done", 32'(train_done), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("abort_no_done", 32'(train_done), 32'd0);
      checkOutput("abort_no_burst", 32'(training), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_lane_sched.md
Name: tx_lane_sched

Overview:
- Word-rate TX lane scheduler that sequences the parallel input of the tree serializer.
- Chooses one source per word-clock cycle:
  - the idle pattern,
  - a training pattern (clock pattern or PRBS7),
  - the mainband data stream (valid/ready).
- Drives a registered WIDTH-bit word into the serializer `din`.
- Runs on the slowest divided clock (serclk[STAGES-1]) and sits between the link controller/data FIFO and tree_ser.

Parameters:
- STAGES, 5, serializer tree depth; WIDTH = 2**STAGES.
- TRAIN_WORDS, 16, number of words sent per training burst (>=1).
- IDLE_WORD, 32'h0000_0000, word sent when no source is active (WIDTH bits).
- PRBS_SEED, 7'h7F, PRBS7 seed loaded on entry to TRAIN (must be non-zero).

Ports:
- clk  in  1  word clock (serclk[STAGES-1]).
- rst  in  1  synchronous, active-high reset.
- train_req  in  1  single-cycle pulse requesting a training burst.
- train_mode  in  1  0 = clock pattern, 1 = PRBS7; sampled when TRAIN is entered.
- data_valid  in  1  upstream word valid.
- data_in  in  WIDTH  upstream word; bit 0 is serialized first.
- data_ready  out  1  scheduler accepts data_in this cycle.
- ser_din  out  WIDTH  registered word to tree_ser din.
- training  out  1  high while the TRAIN state is active.
- train_done  out  1  one-cycle pulse after the last training word is registered.
- train_pend  out  1  a training request is latched but not yet started.

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-high (clk, rst). While rst is high and on the cycle it is sampled:
  - state=IDLE, ser_din=IDLE_WORD, data_ready=0, training=0, train_done=0, train_pend=0;
  - word counter=0, LFSR=PRBS_SEED.
- Reset mid-burst or mid-data aborts immediately: no train_done pulse, and the pending request is dropped.
- All outputs are registered except data_ready, which is a combinational function of state only (not of data_valid).
- States:
  - IDLE: ser_din<=IDLE_WORD, data_ready=0.
    - train_req or train_pend -> TRAIN.
    - else data_valid -> DATA.
  - TRAIN: data_ready=0, training=1.
    - Each cycle ser_din<=pattern word and cnt<=cnt+1.
    - When cnt==TRAIN_WORDS-1 is registered -> IDLE; train_done=1 on the following cycle; cnt<=0.
  - DATA: data_ready=1.
    - valid&ready: ser_din<=data_in; latency is one clk from acceptance to ser_din.
    - !data_valid: ser_din<=IDLE_WORD and next state is IDLE.
    - train_req or train_pend: the current cycle's word is still accepted if valid, then next state is TRAIN.
- Request handling:
  - train_req pulses arriving while not in IDLE/DATA-exit set train_pend.
  - train_pend clears on TRAIN entry.
  - train_req during TRAIN sets train_pend, giving exactly one further burst afterwards; multiple pulses collapse into one.
- Priority: training beats data. IDLE with train_req and data_valid simultaneously -> TRAIN, and data is not accepted.
- Clock pattern: word = {WIDTH/2{2'b01}}, so the line toggles 1,0,1,0 starting with bit 0.
- PRBS7:
  - Polynomial x^7+x^6+1, Fibonacci form; LFSR loaded with PRBS_SEED on the TRAIN entry cycle.
  - Each word holds WIDTH successive LFSR output bits, first bit in bit 0.
  - The LFSR advances WIDTH steps per word; the unrolled next-state logic is combinational.
  - The sequence is continuous across words within a burst and restarts from the seed each burst.
- train_mode is latched on TRAIN entry; changes during a burst are ignored.
- Counter width is $clog2(TRAIN_WORDS+1); the counter never wraps within a burst.
- TRAIN_WORDS==1: a single pattern word, then IDLE; train_done timing is as above.

Decomposition:
- Package tx_sched_pkg holds:
  - enum state_t {IDLE, TRAIN, DATA};
  - CLK_PATTERN generator function;
  - function prbs7_step(lfsr, nbits) returning {next_lfsr, word}.
- Sub-module prbs7_gen: seed load, advance enable, WIDTH-bit word output. It is reused by the RX checker later.

Test Plan:
- Reset: hold rst for 3 clks with data_valid=1 -> ser_din=32'h0, data_ready=0, training=0 throughout; state IDLE on the first clk after release.
- Data streaming: valid=1 with words 1,2,3, then valid=0 -> ser_din shows 1,2,3 one clk after each accept, then 32'h0; data_ready drops the cycle after valid falls.
- Clock training: train_req pulse in IDLE, mode=0 -> 16 consecutive words of 32'h5555_5555; training=1 for 16 clks; train_done pulses once; then IDLE_WORD.
- PRBS training: mode=1 -> ser_din matches the bench PRBS7 model seeded 7'h7F for 16 words; a second burst repeats an identical first word.
- Preemption: train_req while streaming words A,B -> A accepted and registered, next state TRAIN, data_ready=0 during the burst; B is held by upstream and accepted after return to DATA via IDLE.
- Pending and abort: two train_req pulses during a burst -> exactly one extra 16-word burst. rst asserted at word 8 of a burst -> no train_done, train_pend=0, ser_din=IDLE_WORD the next cycle.
